// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute states,
// drives datapath muxes and enables, and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W      = 32,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADDR  = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXEC     = 4'd7;
    localparam logic [3:0] S_RWB      = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_IEXEC    = 4'd10;
    localparam logic [3:0] S_IWB      = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [3:0]       decode_tgt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             last_state;
    logic             retire;

    // Dispatch target chosen in DECODE from the instruction-register opcode
    always_comb begin
        decode_tgt = S_HALT;
        case (op)
            OP_RTYPE: decode_tgt = S_EXEC;
            OP_LW:    decode_tgt = S_MEMADDR;
            OP_SW:    decode_tgt = S_MEMADDR;
            OP_BEQ:   decode_tgt = S_BRANCH;
            OP_BNE:   decode_tgt = ENABLE_BNE ? S_BRANCH : S_HALT;
            OP_ADDI:  decode_tgt = S_IEXEC;
            OP_J:     decode_tgt = S_JUMP;
            default:  decode_tgt = S_HALT;
        endcase
    end

    // Next-state logic; memory states hold until the access completes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_tgt;
            S_MEMADDR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC:     state_d = S_RWB;
            S_RWB:      state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_IEXEC:    state_d = S_IWB;
            S_IWB:      state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            // unused encodings park safely rather than run wild
            default:    state_d = S_HALT;
        endcase
    end

    // An instruction retires when its final state hands back to FETCH
    always_comb begin
        last_state = 1'b0;
        unique case (state_q)
            S_MEMWB, S_MEMWRITE, S_RWB,
            S_BRANCH, S_IWB, S_JUMP: last_state = 1'b1;
            default:                 last_state = 1'b0;
        endcase
        retire  = last_state && (state_d == S_FETCH);
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // State and retirement counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore control outputs, with the FETCH write enables qualified by mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALU_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFF;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_OUT;
                BranchNE    = op[0];
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (full / CNT_W=4 without bne)
// checked every cycle against an instruction-path model plus literal checks.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [5:0] op;

    always #5 clock = ~clock;

    logic a_pcw, a_pcwc, a_bne, a_iord, a_mr, a_mw, a_irw, a_m2r;
    logic a_alusa, a_rw, a_rd, a_halt;
    logic [1:0] a_pcs, a_aluop, a_alusb;
    logic [3:0] a_state;
    logic [31:0] a_cnt;

    logic b_pcw, b_pcwc, b_bne, b_iord, b_mr, b_mw, b_irw, b_m2r;
    logic b_alusa, b_rw, b_rd, b_halt;
    logic [1:0] b_pcs, b_aluop, b_alusb;
    logic [3:0] b_state;
    logic [3:0] b_cnt;

    multicycle_control #(.CNT_W(32), .ENABLE_BNE(1'b1)) dut_a (
        .clock(clock), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .BranchNE(a_bne),
        .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw), .IRWrite(a_irw),
        .MemtoReg(a_m2r), .PCSource(a_pcs), .ALUOp(a_aluop),
        .ALUSrcA(a_alusa), .ALUSrcB(a_alusb), .RegWrite(a_rw),
        .RegDst(a_rd), .halted(a_halt), .state(a_state),
        .instr_count(a_cnt)
    );

    multicycle_control #(.CNT_W(4), .ENABLE_BNE(1'b0)) dut_b (
        .clock(clock), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .BranchNE(b_bne),
        .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw), .IRWrite(b_irw),
        .MemtoReg(b_m2r), .PCSource(b_pcs), .ALUOp(b_aluop),
        .ALUSrcA(b_alusa), .ALUSrcB(b_alusb), .RegWrite(b_rw),
        .RegDst(b_rd), .halted(b_halt), .state(b_state),
        .instr_count(b_cnt)
    );

    logic [17:0] a_vec, b_vec;
    assign a_vec = {a_pcw, a_pcwc, a_bne, a_iord, a_mr, a_mw, a_irw, a_m2r,
                    a_pcs, a_aluop, a_alusa, a_alusb, a_rw, a_rd, a_halt};
    assign b_vec = {b_pcw, b_pcwc, b_bne, b_iord, b_mr, b_mw, b_irw, b_m2r,
                    b_pcs, b_aluop, b_alusa, b_alusb, b_rw, b_rd, b_halt};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected control word for a state, straight from the output table
    function automatic logic [17:0] exp_outs(input int s, input logic mr,
                                             input logic [5:0] o);
        logic pcw = 0, pcwc = 0, bne = 0, iord = 0, mrd = 0, mwr = 0;
        logic irw = 0, m2r = 0, sa = 0, rw = 0, rd = 0, hl = 0;
        logic [1:0] pcs = 0, aop = 0, sb = 0;
        case (s)
            1:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = o[0]; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2'b10; end
            15: hl = 1;
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r,
                pcs, aop, sa, sb, rw, rd, hl};
    endfunction

    // Model: expected state, remaining path of the current instruction, count
    int          ms[2]     = '{0, 0};
    logic [31:0] mc[2]     = '{0, 0};
    int          pth[2][3];
    int          plen[2]   = '{0, 0};
    int          pidx[2]   = '{0, 0};
    int          cw[2]     = '{32, 4};
    bit          en_bne[2] = '{1'b1, 1'b0};

    task automatic set_path(input int k, input int a, input int b,
                            input int c, input int n);
        pth[k][0] = a; pth[k][1] = b; pth[k][2] = c;
        plen[k] = n;
        pidx[k] = 0;
    endtask

    task automatic model_step(input int k);
        logic [31:0] mask;
        mask = (cw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[k]) - 1);
        if (ms[k] == 0) ms[k] = 1;
        else if (ms[k] == 15) ms[k] = 15;
        else if ((ms[k] == 1 || ms[k] == 4 || ms[k] == 6) && !mem_ready) ;
        else if (ms[k] == 1) ms[k] = 2;
        else if (ms[k] == 2) begin
            case (op)
                6'b000000: set_path(k, 7, 8, 0, 2);
                6'b100011: set_path(k, 3, 4, 5, 3);
                6'b101011: set_path(k, 3, 6, 0, 2);
                6'b000100: set_path(k, 9, 0, 0, 1);
                6'b000101: set_path(k, en_bne[k] ? 9 : 15, 0, 0, 1);
                6'b001000: set_path(k, 10, 11, 0, 2);
                6'b000010: set_path(k, 12, 0, 0, 1);
                default:   set_path(k, 15, 0, 0, 1);
            endcase
            ms[k] = pth[k][0];
            pidx[k] = 1;
        end else if (pidx[k] < plen[k]) begin
            ms[k] = pth[k][pidx[k]];
            pidx[k]++;
        end else begin
            ms[k] = 1;
            mc[k] = (mc[k] + 1) & mask;
        end
    endtask

    // Compare on every falling edge, then advance the model for the next edge
    initial forever begin
        @(negedge clock);
        if (reset) begin
            ms = '{0, 0};
            mc = '{0, 0};
        end
        chk("A.state", 32'(a_state), 32'(ms[0]));
        chk("A.outs", 32'(a_vec), 32'(exp_outs(ms[0], mem_ready, op)));
        chk("A.count", a_cnt, mc[0]);
        chk("B.state", 32'(b_state), 32'(ms[1]));
        chk("B.outs", 32'(b_vec), 32'(exp_outs(ms[1], mem_ready, op)));
        chk("B.count", 32'(b_cnt), mc[1]);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cyc(input logic mr);
        mem_ready = mr;
        @(posedge clock);
        #2;
    endtask

    int seq1[6] = '{0, 1, 2, 7, 8, 1};
    logic lw_pat[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    int rec[6];
    int irw_pulses;

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000000;
        repeat (2) @(posedge clock);
        #2;
        chk("rst.state", 32'(a_state), 0);
        chk("rst.outs", 32'(a_vec), 0);
        chk("rst.count", a_cnt, 0);
        reset = 1'b0;

        // R-type: 0,1,2,7,8,1
        rec[0] = 32'(a_state);
        for (int i = 1; i < 6; i++) begin
            cyc(1'b1);
            rec[i] = 32'(a_state);
            if (i == 4) begin
                chk("rwb.regwrite", 32'(a_rw), 1);
                chk("rwb.regdst", 32'(a_rd), 1);
            end
        end
        for (int i = 0; i < 6; i++) chk("rtype.seq", rec[i], seq1[i]);
        chk("rtype.count", a_cnt, 1);

        // lw with 2 fetch waits and 3 read waits
        op = 6'b100011;
        irw_pulses = 0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = lw_pat[i];
            #1;
            irw_pulses += int'(a_irw);
            @(posedge clock);
            #2;
        end
        chk("lw.memwb_state", 32'(a_state), 5);
        chk("lw.memtoreg", 32'(a_m2r), 1);
        chk("lw.irw_pulses", irw_pulses, 1);
        cyc(1'b1);
        chk("lw.count", a_cnt, 2);

        // sw, no waits
        op = 6'b101011;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        chk("sw.state", 32'(a_state), 6);
        chk("sw.memwrite", 32'(a_mw), 1);
        chk("sw.iord", 32'(a_iord), 1);
        chk("sw.memread", 32'(a_mr), 0);
        cyc(1'b1);
        chk("sw.fetch", 32'(a_state), 1);
        chk("sw.count", a_cnt, 3);

        // beq then bne; instance B treats bne as illegal
        op = 6'b000100;
        cyc(1'b1); cyc(1'b1);
        chk("beq.state", 32'(a_state), 9);
        chk("beq.pcwcond", 32'(a_pcwc), 1);
        chk("beq.pcsource", 32'(a_pcs), 1);
        chk("beq.aluop", 32'(a_aluop), 1);
        chk("beq.branchne", 32'(a_bne), 0);
        cyc(1'b1);
        op = 6'b000101;
        cyc(1'b1); cyc(1'b1);
        chk("bne.state", 32'(a_state), 9);
        chk("bne.branchne", 32'(a_bne), 1);
        chk("bne.B_state", 32'(b_state), 15);
        chk("bne.B_halted", 32'(b_halt), 1);
        cyc(1'b1);
        chk("bne.count", a_cnt, 5);
        op = 6'b000000;
        repeat (4) cyc(1'b1);
        chk("bne.B_frozen", 32'(b_cnt), 4);
        chk("bne.A_count", a_cnt, 6);

        // 17 jumps: A counts 17, B (4-bit) wraps to 1
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        cyc(1'b1);
        op = 6'b000010;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1); cyc(1'b1); cyc(1'b1);
        end
        chk("j.A_count", a_cnt, 17);
        chk("j.B_wrap", 32'(b_cnt), 1);

        // reset asserted mid-wait in MEMREAD
        op = 6'b100011;
        cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        chk("midwait.state", 32'(a_state), 4);
        chk("midwait.memread", 32'(a_mr), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("midwait.rst_state", 32'(a_state), 0);
        chk("midwait.rst_outs", 32'(a_vec), 0);
        chk("midwait.rst_B_outs", 32'(b_vec), 0);
        chk("midwait.rst_count", a_cnt, 0);
        cyc(1'b0);
        reset = 1'b0;

        // illegal opcode halts; reset recovers
        cyc(1'b1);
        op = 6'b111111;
        cyc(1'b1); cyc(1'b1);
        chk("halt.state", 32'(a_state), 15);
        chk("halt.halted", 32'(a_halt), 1);
        repeat (20) cyc(1'b1);
        chk("halt.stay", 32'(a_state), 15);
        chk("halt.count", a_cnt, 0);
        reset = 1'b1;
        #1;
        chk("halt.rst_state", 32'(a_state), 0);
        chk("halt.rst_count", a_cnt, 0);
        cyc(1'b1);
        reset = 1'b0;
        cyc(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style control FSM that sequences the multi-cycle MIPS datapath: one shared memory, instruction register, ALUOut register, and a PC written under control. It replaces the single-cycle Control decoder for the multi-cycle CPU. Each instruction takes 3–5 states, plus memory wait states inserted by a ready handshake. It decodes the opcode from the instruction register, drives every datapath mux and write enable, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
ENABLE_BNE, 1, when 1 opcode 000101 (bne) is legal; when 0 it is an illegal opcode

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  opcode, instr[31:26] from the instruction register
mem_ready  input  1  shared memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by the branch condition
BranchNE  output  1  branch condition polarity: 1 = take on ~Zero, 0 = take on Zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data select: 1 = memory data register
PCSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
ALUOp  output  2  00 = add, 01 = sub, 10 = funct field
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
RegWrite  output  1  register file write enable
RegDst  output  1  write address select: 1 = rd, 0 = rt
halted  output  1  FSM is in HALT
state  output  4  current state encoding, for debug
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- One clock domain (clock). reset is asynchronous and active-high. On reset: state = IDLE, instr_count = 0.
- In IDLE, HALT and during reset, all control outputs are 0.
- State encoding is fixed: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXEC 7, RWB 8, BRANCH 9, IEXEC 10, IWB 11, JUMP 12, HALT 15.
- Any output not listed for a state below is 0 in that state.
- IDLE -> FETCH unconditionally on the first clock edge after reset deasserts.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy qualification).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by op: 000000 -> EXEC; 100011 lw or 101011 sw -> MEMADDR; 000100 beq -> BRANCH; 000101 bne -> BRANCH if ENABLE_BNE, else HALT; 001000 addi -> IEXEC; 000010 j -> JUMP; any other opcode -> HALT.
- MEMADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMREAD if op=100011, else MEMWRITE.
- MEMREAD:
  - Outputs: MemRead=1, IorD=1.
  - Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next state FETCH.
- MEMWRITE:
  - Outputs: MemWrite=1, IorD=1.
  - Holds while mem_ready=0; goes to FETCH when mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=op[0].
  - Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
- JUMP: PCWrite=1, PCSource=10; next state FETCH.
- HALT: halted=1; absorbing state, left only by reset.
- BranchNE is driven only in BRANCH; it is 0 in every other state.
- Memory access rules:
  - At most one of MemRead/MemWrite is 1 in any cycle.
  - The memory request stays asserted and stable until mem_ready=1.
- Retirement: instr_count increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWRITE, RWB, BRANCH, IWB or JUMP.
  - IDLE -> FETCH does not count.
  - HALT never counts.
- Nominal cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- reset asserted in any state, including mid-wait: the FSM immediately returns to IDLE and outputs drop to 0 asynchronously. No partial write is committed after reset asserts.

Test Plan:
1. Release reset, mem_ready=1, op=000000 -> state sequence 0,1,2,7,8,1; RWB cycle has RegWrite=1, RegDst=1; instr_count=1.
2. op=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite pulse exactly once, when mem_ready rises; MEMWB reached after 10 cycles; MemtoReg=1 there.
3. op=101011 with mem_ready=1 -> MEMWRITE for 1 cycle with MemWrite=1, IorD=1, MemRead=0, then FETCH; instr_count +1.
4. op=000100 then op=000101 -> BRANCH has PCWriteCond=1, PCSource=01, ALUOp=01, BranchNE=0 then 1. With ENABLE_BNE=0, op=000101 -> HALT, halted=1, counter frozen.
5. op=111111 -> HALT after DECODE; 20 further clocks keep state=15; reset -> state=0, instr_count=0.
6. Assert reset while in MEMREAD with mem_ready=0 -> outputs go to 0 before the next edge. CNT_W=4 with 17 j instructions -> instr_count wraps to 1.
